// File: rtl/rate_limiter_pacer.sv
// Packet-release pacer: grants one packet at a time, then holds off for pkt_bytes << shift cycles.
// Optional statistics counters are built only when RATE_LIMITER_PACER_STATS_EN is defined.
module rate_limiter_pacer #(
    parameter int unsigned SHIFT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_rate_limit,
    input  logic [15:0] thruput_shift,
    input  logic        pkt_avail,
    input  logic        out_rdy,
    input  logic        pkt_done,
    input  logic [15:0] pkt_bytes,
    output logic        pkt_grant,
    output logic        rate_wait,
    output logic [31:0] stat_pkts,
    output logic [31:0] stat_wait_cycles
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [15:0] SHIFT_LIMIT = SHIFT_MAX[15:0];

    function automatic logic [31:0] gap_len(input logic [15:0] bytes, input logic [15:0] shift);
        logic [15:0] shift_eff;
        shift_eff = (shift > SHIFT_LIMIT) ? SHIFT_LIMIT : shift;
        return {16'd0, bytes} << shift_eff;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [31:0] delay_cnt_r;
    logic [31:0] delay_cnt_nxt_s;
    logic [31:0] gap_s;
    logic        pkt_grant_r;
    logic        rate_wait_r;

    // Next-state and gap-counter logic; the counter exits at 1 so it can never wrap below zero
    always_comb begin
        state_nxt_s     = state_r;
        delay_cnt_nxt_s = delay_cnt_r;
        gap_s           = gap_len(pkt_bytes, thruput_shift);
        case (state_r)
            IDLE: begin
                if (pkt_avail && out_rdy) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (pkt_done) begin
                    if (!enable_rate_limit || (gap_s == 32'd0)) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s     = WAIT;
                        delay_cnt_nxt_s = gap_s;
                    end
                end else begin
                    state_nxt_s = SEND;
                end
            end
            WAIT: begin
                if (!enable_rate_limit || (delay_cnt_r <= 32'd1)) begin
                    state_nxt_s     = IDLE;
                    delay_cnt_nxt_s = 32'd0;
                end else begin
                    state_nxt_s     = WAIT;
                    delay_cnt_nxt_s = delay_cnt_r - 32'd1;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                delay_cnt_nxt_s = 32'd0;
            end
        endcase
    end

    // State, counter and registered status outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            delay_cnt_r <= 32'd0;
            pkt_grant_r <= 1'b0;
            rate_wait_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            delay_cnt_r <= delay_cnt_nxt_s;
            pkt_grant_r <= (state_nxt_s == SEND);
            rate_wait_r <= (state_nxt_s == WAIT);
        end
    end

    assign pkt_grant = pkt_grant_r;
    assign rate_wait = rate_wait_r;

`ifdef RATE_LIMITER_PACER_STATS_EN
    logic [31:0] stat_pkts_r;
    logic [31:0] stat_wait_cycles_r;

    // Free-running statistics, wrapping modulo 2^32 and cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_pkts_r        <= 32'd0;
            stat_wait_cycles_r <= 32'd0;
        end else begin
            if ((state_r == SEND) && pkt_done) begin
                stat_pkts_r <= stat_pkts_r + 32'd1;
            end
            if (state_r == WAIT) begin
                stat_wait_cycles_r <= stat_wait_cycles_r + 32'd1;
            end
        end
    end

    assign stat_pkts        = stat_pkts_r;
    assign stat_wait_cycles = stat_wait_cycles_r;
`else
    assign stat_pkts        = 32'd0;
    assign stat_wait_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_rate_limiter_pacer.sv
// Directed self-checking bench for rate_limiter_pacer; stats expectations follow RATE_LIMITER_PACER_STATS_EN.
module tb_rate_limiter_pacer;

`ifdef RATE_LIMITER_PACER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        enable_rate_limit;
    logic [15:0] thruput_shift;
    logic        pkt_avail;
    logic        out_rdy;
    logic        pkt_done;
    logic [15:0] pkt_bytes;
    logic        pkt_grant;
    logic        rate_wait;
    logic [31:0] stat_pkts;
    logic [31:0] stat_wait_cycles;

    int total = 0;
    int bad   = 0;

    rate_limiter_pacer #(.SHIFT_MAX(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable_rate_limit (enable_rate_limit),
        .thruput_shift     (thruput_shift),
        .pkt_avail         (pkt_avail),
        .out_rdy           (out_rdy),
        .pkt_done          (pkt_done),
        .pkt_bytes         (pkt_bytes),
        .pkt_grant         (pkt_grant),
        .rate_wait         (rate_wait),
        .stat_pkts         (stat_pkts),
        .stat_wait_cycles  (stat_wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    initial begin
        int k;
        int nw;
        logic seen;

        reset = 1'b1; enable_rate_limit = 1'b0; thruput_shift = 16'd0;
        pkt_avail = 1'b0; out_rdy = 1'b0; pkt_done = 1'b0; pkt_bytes = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_grant", pkt_grant, 32'd0);
        chk("rst_wait", rate_wait, 32'd0);
        chk("rst_pkts", stat_pkts, 32'd0);
        chk("rst_wcyc", stat_wait_cycles, 32'd0);

        // Unpaced packet: next grant two cycles after pkt_done
        reset = 1'b0; pkt_avail = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        chk("first_grant", pkt_grant, 32'd1);
        pkt_bytes = 16'd64; pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("unp_grant_low", pkt_grant, 32'd0);
        chk("unp_wait_low", rate_wait, 32'd0);
        @(negedge clk);
        chk("unp_regrant", pkt_grant, 32'd1);
        chk("unp_wait_low2", rate_wait, 32'd0);
        chk("unp_pkts", stat_pkts, sx(32'd1));

        // Paced: shift 2, 60 bytes -> 240-cycle gap, grant at +242
        enable_rate_limit = 1'b1; thruput_shift = 16'd2; pkt_bytes = 16'd60; pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("pace_wait_on", rate_wait, 32'd1);
        chk("pace_grant_off", pkt_grant, 32'd0);
        k = 1; nw = 1;
        while (pkt_grant !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
            if (rate_wait === 1'b1) nw++;
        end
        chk("pace_wait_len", nw, 32'd240);
        chk("pace_regrant_at", k, 32'd242);
        chk("pace_wcyc", stat_wait_cycles, sx(32'd240));
        chk("pace_pkts", stat_pkts, sx(32'd2));

        // Clamp: shift 20 clamps to 16; drop enable at WAIT cycle 10
        thruput_shift = 16'd20; pkt_bytes = 16'hFFFF; pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("clamp_load", dut.delay_cnt_r, 32'hFFFF0000);
        chk("clamp_wait_on", rate_wait, 32'd1);
        repeat (9) @(negedge clk);
        chk("clamp_cnt10", dut.delay_cnt_r, 32'hFFFEFFF7);
        chk("clamp_wait10", rate_wait, 32'd1);
        enable_rate_limit = 1'b0; pkt_avail = 1'b0;
        @(negedge clk);
        chk("clamp_abort_wait", rate_wait, 32'd0);
        chk("clamp_abort_grant", pkt_grant, 32'd0);
        chk("clamp_wcyc", stat_wait_cycles, sx(32'd250));
        chk("clamp_pkts", stat_pkts, sx(32'd3));

        // Backpressure with a stray pkt_done while IDLE
        pkt_avail = 1'b1; out_rdy = 1'b0; enable_rate_limit = 1'b1;
        thruput_shift = 16'd0; pkt_bytes = 16'd5; seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | pkt_grant | rate_wait;
        end
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("idle_done_grant", pkt_grant, 32'd0);
        chk("idle_done_wait", rate_wait, 32'd0);
        chk("idle_done_pkts", stat_pkts, sx(32'd3));
        repeat (29) begin
            @(negedge clk);
            seen = seen | pkt_grant | rate_wait;
        end
        chk("bp_no_grant", seen, 32'd0);
        out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_grant", pkt_grant, 32'd1);

        // Zero-length packet with pacing active: no gap
        thruput_shift = 16'd3; pkt_bytes = 16'd0; pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("zero_wait", rate_wait, 32'd0);
        chk("zero_grant_off", pkt_grant, 32'd0);
        @(negedge clk);
        chk("zero_regrant", pkt_grant, 32'd1);
        chk("zero_pkts", stat_pkts, sx(32'd4));

        // Reset during WAIT with 100 cycles left
        thruput_shift = 16'd0; pkt_bytes = 16'd200; pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("rw_load", dut.delay_cnt_r, 32'd200);
        repeat (100) @(negedge clk);
        chk("rw_cnt100", dut.delay_cnt_r, 32'd100);
        chk("rw_wait_on", rate_wait, 32'd1);
        reset = 1'b1; pkt_avail = 1'b0;
        @(negedge clk);
        chk("rw_wait_off", rate_wait, 32'd0);
        chk("rw_grant_off", pkt_grant, 32'd0);
        chk("rw_cnt_clr", dut.delay_cnt_r, 32'd0);
        chk("rw_pkts_clr", stat_pkts, 32'd0);
        chk("rw_wcyc_clr", stat_wait_cycles, 32'd0);
        reset = 1'b0; pkt_avail = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", pkt_grant, 32'd1);
        enable_rate_limit = 1'b0; pkt_bytes = 16'd64; pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("post_rst_grant_off", pkt_grant, 32'd0);
        chk("post_rst_pkts", stat_pkts, sx(32'd1));
        @(negedge clk);
        chk("post_rst_regrant", pkt_grant, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
